// File: rtl/async_pkg.sv
// Shared helpers for the async req/ack operator library: width helpers and
// the protocol-error message used by every operator in the fabric.
`define ASYNC_PROTOCOL_ERROR(msg) $error("%m: req/ack protocol error: %s", msg)

package async_pkg;

    // Bits needed to hold any count in 0..max_value.
    function automatic int width_for_count(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    // Bits needed to address depth slots; a single slot still gets one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// DEPTH-slot circular storage with wrap-around pointers, occupancy counter and
// an optional preload of INIT_COUNT identical tokens for feedback edges.
module async_fifo_mem
    import async_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    INIT_COUNT = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   CW         = width_for_count(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ret,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         occupancy,
    output logic [CW-1:0]         occ_next
);

    localparam int            PW      = ptr_width(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [PW-1:0] WR_INIT = PW'(INIT_COUNT % DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_accept;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A word arriving while full is dropped; the top level flags it.
    assign wr_accept = wr_en && (occupancy != FULL);
    assign rd_data   = mem[rd_ptr];

    always_comb begin
        occ_next = occupancy;
        if (wr_accept && !ret) begin
            occ_next = occupancy + 1'b1;
        end else if (!wr_accept && ret) begin
            occ_next = occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i < INIT_COUNT) ? INIT_VALUE : '0;
            end
            wr_ptr    <= WR_INIT;
            rd_ptr    <= '0;
            occupancy <= CW'(INIT_COUNT);
        end else begin
            if (wr_accept) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (ret) begin
                rd_ptr <= bump(rd_ptr);
            end
            occupancy <= occ_next;
        end
    end

endmodule

// File: rtl/async_elastic_fork.sv
// Elastic req/ack buffer with fan-out: one producer, OUTPUT_SIZE consumers that
// each take every word once; the head retires when the slowest consumer has it.
module async_elastic_fork
    import async_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 4,
    parameter int                    OUTPUT_SIZE = 1,
    parameter int                    INIT_COUNT  = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    localparam int                   CW          = width_for_count(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              req_l,
    input  logic                              ack_l,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic [OUTPUT_SIZE-1:0]            req_r,
    output logic [OUTPUT_SIZE-1:0]            ack_r,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]                     occupancy
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [OUTPUT_SIZE-1:0] taken;
    logic [OUTPUT_SIZE-1:0] issue;
    logic [DATA_WIDTH-1:0]  head;
    logic [CW-1:0]          occ_next;
    logic                   head_valid;
    logic                   retire;

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_COUNT (INIT_COUNT),
        .INIT_VALUE (INIT_VALUE)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (ack_l),
        .wr_data   (din),
        .ret       (retire),
        .rd_data   (head),
        .occupancy (occupancy),
        .occ_next  (occ_next)
    );

    // A consumer is served only between its own pulses and only once per head word,
    // so nobody can run ahead of the slowest consumer.
    assign head_valid = (occupancy != '0);
    assign issue      = req_r & ~ack_r & ~taken & {OUTPUT_SIZE{head_valid}};
    assign retire     = head_valid && (&(taken | issue));

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l <= 1'b0;
            ack_r <= '0;
            taken <= '0;
            dout  <= '0;
        end else begin
            req_l <= !ack_l && (occ_next < FULL);
            ack_r <= issue;
            taken <= retire ? '0 : (taken | issue);
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                if (issue[j]) begin
                    dout[j*DATA_WIDTH +: DATA_WIDTH] <= head;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ack_l && (occupancy == FULL)) begin
            `ASYNC_PROTOCOL_ERROR("ack_l while full, word dropped");
        end
    end

endmodule

// File: tb/tb_async_elastic_fork.sv
// Self-checking bench for async_elastic_fork: directed vector table, corner sequences
// and randomized traffic checked against a queue-based scoreboard.
module tb_async_elastic_fork;

    localparam int            DW    = 16;
    localparam int            DEPTH = 4;
    localparam int            OS    = 3;
    localparam int            IC    = 2;
    localparam logic [DW-1:0] IV    = 16'd7;
    localparam int            CW    = $clog2(DEPTH + 1);

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            ack_l = 1'b0;
    logic            req_l;
    logic [DW-1:0]   din   = '0;
    logic [OS-1:0]   req_r = '0;
    logic [OS-1:0]   ack_r;
    logic [OS*DW-1:0] dout;
    logic [CW-1:0]   occupancy;

    async_elastic_fork #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .OUTPUT_SIZE (OS),
        .INIT_COUNT  (IC),
        .INIT_VALUE  (IV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_l     (req_l),
        .ack_l     (ack_l),
        .din       (din),
        .req_r     (req_r),
        .ack_r     (ack_r),
        .dout      (dout),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard: the queue holds every stored word in arrival order; got[j] marks
    // that consumer j already holds the head word.
    logic [DW-1:0] model_q[$];
    int            got[OS];
    logic [DW-1:0] exp_dout[OS];
    logic [OS-1:0] prev_ack = '0;
    int            ack_cnt[OS];
    bit            mon_en = 1'b0;

    task automatic modelStep();
        int            pre;
        logic [OS-1:0] exp_vec;
        bit            all_got;
        if (rst) begin
            model_q.delete();
            for (int i = 0; i < IC; i++) model_q.push_back(IV);
            for (int j = 0; j < OS; j++) begin
                got[j]      = 0;
                exp_dout[j] = '0;
            end
            prev_ack = '0;
            checkOutput("rst_ack_r", int'(ack_r), 0);
            checkOutput("rst_occupancy", int'(occupancy), IC);
            checkOutput("rst_req_l", int'(req_l), 0);
            checkOutput("rst_dout_any", int'(|dout), 0);
            return;
        end
        pre     = model_q.size();
        exp_vec = '0;
        for (int j = 0; j < OS; j++) begin
            exp_vec[j] = req_r[j] && !prev_ack[j] && (pre > 0) && (got[j] == 0);
            checkOutput($sformatf("ack_r[%0d]", j), int'(ack_r[j]), int'(exp_vec[j]));
            if (ack_r[j]) ack_cnt[j]++;
            if (exp_vec[j]) begin
                exp_dout[j] = model_q[0];
                got[j]      = 1;
            end
        end
        if (ack_l && pre < DEPTH) model_q.push_back(din);
        all_got = 1'b1;
        for (int j = 0; j < OS; j++) if (got[j] == 0) all_got = 1'b0;
        if (all_got) begin
            model_q.delete(0);
            for (int j = 0; j < OS; j++) got[j] = 0;
        end
        checkOutput("occupancy", int'(occupancy), model_q.size());
        checkOutput("req_l", int'(req_l), int'(!ack_l && model_q.size() < DEPTH));
        for (int j = 0; j < OS; j++) begin
            checkOutput($sformatf("dout[%0d]", j), int'(dout[j*DW +: DW]), int'(exp_dout[j]));
        end
        prev_ack = exp_vec;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) modelStep();
    end

    typedef struct {
        logic          rst;
        logic          ack_l;
        logic [DW-1:0] din;
        logic [OS-1:0] req_r;
        logic          exp_req_l;
        logic [OS-1:0] exp_ack_r;
        int            exp_occ;
        logic [DW-1:0] exp_dout0;
    } vec_t;

    vec_t    vecs[20];
    int      next_val = 0;
    int      snap[OS];

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst   = v.rst;
        ack_l = v.ack_l;
        din   = v.din;
        req_r = v.req_r;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst      = 1'b1;
        ack_l    = 1'b0;
        req_r    = '0;
        next_val = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Producer answers req_l with probability prod_pct; consumers hold or randomize req_r.
    task automatic runCycles(input int n, input int prod_pct, input logic [OS-1:0] mask, input bit rand_req);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (req_l && !ack_l && ($urandom_range(0, 99) < prod_pct)) begin
                ack_l = 1'b1;
                din   = DW'(next_val);
                next_val++;
            end else begin
                ack_l = 1'b0;
            end
            req_r = rand_req ? (OS'($urandom()) & mask) : mask;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        n_fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 16'd55, 3'b111, 1'b0, 3'b000, 2, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 16'd0,  3'b000, 1'b1, 3'b000, 2, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 16'd10, 3'b000, 1'b0, 3'b000, 3, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 16'd0,  3'b101, 1'b1, 3'b101, 3, 16'd7};
        vecs[4]  = '{1'b0, 1'b1, 16'd11, 3'b111, 1'b0, 3'b010, 3, 16'd7};
        vecs[5]  = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b101, 3, 16'd7};
        vecs[6]  = '{1'b0, 1'b1, 16'd12, 3'b111, 1'b0, 3'b010, 3, 16'd7};
        vecs[7]  = '{1'b0, 1'b0, 16'd0,  3'b000, 1'b1, 3'b000, 3, 16'd7};
        vecs[8]  = '{1'b0, 1'b1, 16'd13, 3'b000, 1'b0, 3'b000, 4, 16'd7};
        vecs[9]  = '{1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 3'b000, 4, 16'd7};
        vecs[10] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b111, 3, 16'd10};
        vecs[11] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b000, 3, 16'd10};
        vecs[12] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b111, 2, 16'd11};
        vecs[13] = '{1'b0, 1'b0, 16'd0,  3'b000, 1'b1, 3'b000, 2, 16'd11};
        vecs[14] = '{1'b1, 1'b0, 16'd0,  3'b000, 1'b0, 3'b000, 2, 16'd0};
        vecs[15] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b111, 1, 16'd7};
        vecs[16] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b000, 1, 16'd7};
        vecs[17] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b111, 0, 16'd7};
        vecs[18] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b000, 0, 16'd7};
        vecs[19] = '{1'b0, 1'b0, 16'd0,  3'b111, 1'b1, 3'b000, 0, 16'd7};
        for (int j = 0; j < OS; j++) ack_cnt[j] = 0;

        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_req_l", i), int'(req_l), int'(vecs[i].exp_req_l));
            checkOutput($sformatf("vec%0d_ack_r", i), int'(ack_r), int'(vecs[i].exp_ack_r));
            checkOutput($sformatf("vec%0d_occ", i), int'(occupancy), vecs[i].exp_occ);
            checkOutput($sformatf("vec%0d_dout0", i), int'(dout[DW-1:0]), int'(vecs[i].exp_dout0));
        end

        $display("[TB] slow consumer holds back the head");
        applyReset();
        snap = ack_cnt;
        runCycles(20, 0, 3'b101, 1'b0);
        checkOutput("t3_c0_once", ack_cnt[0] - snap[0], 1);
        checkOutput("t3_c1_none", ack_cnt[1] - snap[1], 0);
        checkOutput("t3_c2_once", ack_cnt[2] - snap[2], 1);
        checkOutput("t3_occ_held", int'(occupancy), 2);
        runCycles(1, 0, 3'b111, 1'b0);
        checkOutput("t3_c1_ack", ack_cnt[1] - snap[1], 1);
        checkOutput("t3_retire_occ", int'(occupancy), 1);

        $display("[TB] streaming throughput");
        applyReset();
        runCycles(20, 100, 3'b111, 1'b0);
        snap = ack_cnt;
        runCycles(200, 100, 3'b111, 1'b0);
        for (int j = 0; j < OS; j++) begin
            checkOutput($sformatf("t1_rate_c%0d", j), ack_cnt[j] - snap[j], 100);
        end

        $display("[TB] fill while consumers stall, then drain");
        applyReset();
        runCycles(20, 100, 3'b000, 1'b0);
        checkOutput("t2_full_occ", int'(occupancy), DEPTH);
        checkOutput("t2_full_req_l", int'(req_l), 0);
        snap = ack_cnt;
        runCycles(1, 0, 3'b111, 1'b0);
        checkOutput("t2_req_l_back", int'(req_l), 1);
        checkOutput("t2_occ_after_first", int'(occupancy), DEPTH - 1);
        runCycles(8, 0, 3'b111, 1'b0);
        checkOutput("t2_drained_acks", ack_cnt[0] - snap[0], DEPTH);
        checkOutput("t2_drained_occ", int'(occupancy), 0);

        $display("[TB] reset with a word in flight");
        applyReset();
        runCycles(2, 100, 3'b000, 1'b0);
        checkOutput("t6_pre_occ", int'(occupancy), 3);
        checkOutput("t6_pre_req_l", int'(req_l), 1);
        @(negedge clk);
        rst   = 1'b1;
        ack_l = 1'b1;
        din   = 16'd99;
        @(posedge clk);
        #1;
        checkOutput("t6_occ", int'(occupancy), IC);
        checkOutput("t6_ack_r", int'(ack_r), 0);
        @(negedge clk);
        rst      = 1'b0;
        ack_l    = 1'b0;
        next_val = 0;
        @(posedge clk);
        #1;
        snap = ack_cnt;
        runCycles(40, 70, 3'b111, 1'b1);
        checkOutput("t6_restart", int'((ack_cnt[0] - snap[0]) > 0), 1);

        $display("[TB] randomized traffic");
        for (int b = 0; b < 25; b++) begin
            if ($urandom_range(0, 3) == 0) applyReset();
            runCycles(100, $urandom_range(20, 100), 3'b111, 1'b1);
        end
        runCycles(30, 0, 3'b111, 1'b0);
        checkOutput("final_drain_occ", int'(occupancy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
